// File: rtl/csr_pkg.sv
// Shared CSR addresses, trap causes, operation encodings and small helpers
// for the machine-mode CSR / trap unit.
package csr_pkg;

   localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
   localparam logic [11:0] CSR_MARCHID       = 12'hF12;
   localparam logic [11:0] CSR_MIMPID        = 12'hF13;
   localparam logic [11:0] CSR_MHARTID       = 12'hF14;
   localparam logic [11:0] CSR_MSTATUS       = 12'h300;
   localparam logic [11:0] CSR_MISA          = 12'h301;
   localparam logic [11:0] CSR_MTVEC         = 12'h305;
   localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
   localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
   localparam logic [11:0] CSR_MEPC          = 12'h341;
   localparam logic [11:0] CSR_MCAUSE        = 12'h342;
   localparam logic [11:0] CSR_MTVAL         = 12'h343;

   // 32-entry address pages, selected by csr_addr[11:5]
   localparam logic [6:0]  CSR_MHPMEVENT_PAGE = 7'h19;   // 0x320..0x33F
   localparam logic [6:0]  CSR_CNT_LO_PAGE    = 7'h58;   // 0xB00..0xB1F
   localparam logic [6:0]  CSR_CNT_HI_PAGE    = 7'h5C;   // 0xB80..0xB9F

   localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

   localparam logic [3:0] CAUSE_INST_MISALIGNED  = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL_INST     = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

   typedef enum logic [1:0] {
      CSR_OP_NONE  = 2'b00,
      CSR_OP_WRITE = 2'b01,
      CSR_OP_SET   = 2'b10,
      CSR_OP_CLEAR = 2'b11
   } csr_op_e;

   typedef enum logic {
      ST_IDLE,
      ST_REDIRECT
   } trap_state_e;

   // CSR counter number of physical counter k: mcycle, minstret, then hpm3..
   function automatic logic [4:0] cnt_csr_idx(input int unsigned k);
      if (k == 0)      return 5'd0;
      else if (k == 1) return 5'd2;
      else             return 5'(k + 1);
   endfunction

   // Writable mcountinhibit bits: CY, IR and each implemented HPM counter
   function automatic logic [31:0] minh_mask(input int unsigned num_hpm);
      logic [31:0] m;
      m = 32'h1;
      for (int unsigned b = 2; b < 3 + num_hpm; b++) m[b] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/csr_counter.sv
// Width-parametrised event counter with inhibit and 32-bit half write ports.
module csr_counter #(
   parameter int unsigned CNT_WIDTH = 64
) (
   input  logic                 clk,
   input  logic                 resetb,
   input  logic                 i_inc,
   input  logic                 i_inhibit,
   input  logic                 i_wr_lo,
   input  logic                 i_wr_hi,
   input  logic [31:0]          i_wdata,
   output logic [CNT_WIDTH-1:0] o_count
);

   logic [CNT_WIDTH-1:0] r_count;

   // A half write replaces the increment for that cycle
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_count <= '0;
      end else if (i_wr_lo) begin
         r_count[31:0] <= i_wdata;
      end else if (i_wr_hi) begin
         r_count[CNT_WIDTH-1:32] <= i_wdata[CNT_WIDTH-33:0];
      end else if (i_inc && !i_inhibit) begin
         r_count <= r_count + CNT_WIDTH'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with counters and a precise trap / mret sequencer.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int unsigned CNT_WIDTH   = 64,
   parameter int unsigned NUM_HPM     = 2,
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
   parameter int unsigned HART_ID     = 0
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic        csr_valid,
   input  logic [1:0]  csr_op,
   input  logic        csr_imm,
   input  logic [11:0] csr_addr,
   input  logic [31:0] csr_rs1,
   input  logic [4:0]  csr_uimm,
   input  logic        csr_rd_nz,
   output logic [31:0] csr_rdata,
   input  logic        retire,
   input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_event,
   input  logic        xb_exc_valid,
   input  logic [3:0]  xb_exc_cause,
   input  logic [31:0] xb_pc,
   input  logic [31:0] xb_tval,
   input  logic        fd_exc_valid,
   input  logic [3:0]  fd_exc_cause,
   input  logic [31:0] fd_pc,
   input  logic [31:0] fd_tval,
   input  logic        mret,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        mstatus_mie
);

   localparam int unsigned NCNT      = 2 + NUM_HPM;
   localparam logic [31:0] MINH_MASK = minh_mask(NUM_HPM);

   trap_state_e r_state;
   logic        r_redirect;
   logic [31:0] r_rpc;
   logic [31:0] r_rdata;
   logic        r_mie;
   logic        r_mpie;
   logic [31:0] r_mtvec;
   logic [31:0] r_mscratch;
   logic [31:0] r_mepc;
   logic [31:0] r_mcause;
   logic [31:0] r_mtval;
   logic [31:0] r_minh;

   logic                 w_idle;
   logic                 w_known;
   logic [31:0]          w_rdata;
   logic                 w_wr_intent;
   logic                 w_illegal;
   logic                 w_trap;
   logic                 w_wen;
   logic [31:0]          w_operand;
   logic [31:0]          w_wval;
   logic [31:0]          w_trap_pc;
   logic [3:0]           w_trap_cause;
   logic [31:0]          w_trap_tval;
   logic [NCNT-1:0]      w_inc;
   logic [NCNT-1:0]      w_inh;
   logic [NCNT-1:0]      w_wr_lo;
   logic [NCNT-1:0]      w_wr_hi;
   logic [CNT_WIDTH-1:0] w_cnt [NCNT];

   // CSR read mux and address decode (reads have no side effects)
   always_comb begin
      w_rdata = '0;
      w_known = 1'b1;
      case (csr_addr)
         CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: w_rdata = '0;
         CSR_MHARTID:       w_rdata = 32'(HART_ID);
         CSR_MSTATUS: begin
            w_rdata[12:11]        = 2'b11;
            w_rdata[MSTATUS_MPIE] = r_mpie;
            w_rdata[MSTATUS_MIE]  = r_mie;
         end
         CSR_MISA:          w_rdata = MISA_VALUE;
         CSR_MTVEC:         w_rdata = r_mtvec;
         CSR_MCOUNTINHIBIT: w_rdata = r_minh;
         CSR_MSCRATCH:      w_rdata = r_mscratch;
         CSR_MEPC:          w_rdata = r_mepc;
         CSR_MCAUSE:        w_rdata = r_mcause;
         CSR_MTVAL:         w_rdata = r_mtval;
         default: begin
            if (csr_addr[11:5] == CSR_MHPMEVENT_PAGE && csr_addr[4:0] >= 5'd3) begin
               w_rdata = '0;
            end else if ((csr_addr[11:5] == CSR_CNT_LO_PAGE || csr_addr[11:5] == CSR_CNT_HI_PAGE)
                         && csr_addr[4:0] != 5'd1) begin
               for (int unsigned k = 0; k < NCNT; k++) begin
                  if (cnt_csr_idx(k) == csr_addr[4:0]) begin
                     w_rdata = (csr_addr[11:5] == CSR_CNT_HI_PAGE)
                               ? 32'(w_cnt[k][CNT_WIDTH-1:32]) : w_cnt[k][31:0];
                  end
               end
            end else begin
               w_known = 1'b0;
            end
         end
      endcase
   end

   // Write intent, illegal-access detection, trap priority and write value
   always_comb begin
      w_idle      = (r_state == ST_IDLE);
      w_wr_intent = (csr_op == CSR_OP_WRITE) ||
                    ((csr_op == CSR_OP_SET || csr_op == CSR_OP_CLEAR) && csr_uimm != 5'd0);
      w_illegal   = w_idle && csr_valid &&
                    (!w_known || (csr_addr[11:8] == 4'hF && w_wr_intent));
      w_trap      = w_idle && (w_illegal || xb_exc_valid || fd_exc_valid);
      w_wen       = w_idle && csr_valid && w_wr_intent && !w_trap;
      w_operand   = csr_imm ? {27'b0, csr_uimm} : csr_rs1;
      case (csr_op)
         CSR_OP_SET:   w_wval = w_rdata | w_operand;
         CSR_OP_CLEAR: w_wval = w_rdata & ~w_operand;
         default:      w_wval = w_operand;
      endcase
      if (w_illegal) begin
         w_trap_pc    = xb_pc;
         w_trap_cause = CAUSE_ILLEGAL_INST;
         w_trap_tval  = '0;
      end else if (xb_exc_valid) begin
         w_trap_pc    = xb_pc;
         w_trap_cause = xb_exc_cause;
         w_trap_tval  = xb_tval;
      end else begin
         w_trap_pc    = fd_pc;
         w_trap_cause = fd_exc_cause;
         w_trap_tval  = fd_tval;
      end
   end

   // Counter strobes: mcycle always runs, the rest are frozen while flushing
   always_comb begin
      w_inc    = '0;
      w_inc[0] = 1'b1;
      w_inc[1] = w_idle && retire && !w_trap;
      for (int unsigned i = 0; i < NUM_HPM; i++) w_inc[2+i] = w_idle && hpm_event[i];
      for (int unsigned k = 0; k < NCNT; k++) begin
         w_inh[k]   = r_minh[cnt_csr_idx(k)];
         w_wr_lo[k] = w_wen && (csr_addr == {CSR_CNT_LO_PAGE, cnt_csr_idx(k)});
         w_wr_hi[k] = w_wen && (csr_addr == {CSR_CNT_HI_PAGE, cnt_csr_idx(k)});
      end
   end

   for (genvar g = 0; g < NCNT; g++) begin : g_cnt
      csr_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
         .clk       (clk),
         .resetb    (resetb),
         .i_inc     (w_inc[g]),
         .i_inhibit (w_inh[g]),
         .i_wr_lo   (w_wr_lo[g]),
         .i_wr_hi   (w_wr_hi[g]),
         .i_wdata   (w_wval),
         .o_count   (w_cnt[g])
      );
   end

   // CSR state updates and the IDLE/REDIRECT sequencer
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         r_state    <= ST_IDLE;
         r_redirect <= 1'b0;
         r_rpc      <= '0;
         r_rdata    <= '0;
         r_mie      <= 1'b0;
         r_mpie     <= 1'b1;
         r_mtvec    <= {MTVEC_RESET[31:2], 2'b00};
         r_mscratch <= '0;
         r_mepc     <= '0;
         r_mcause   <= '0;
         r_mtval    <= '0;
         r_minh     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_redirect <= 1'b0;
               if (csr_valid && csr_rd_nz && !w_trap) r_rdata <= w_rdata;
               if (w_wen) begin
                  case (csr_addr)
                     CSR_MSTATUS: begin
                        r_mie  <= w_wval[MSTATUS_MIE];
                        r_mpie <= w_wval[MSTATUS_MPIE];
                     end
                     CSR_MTVEC:         r_mtvec    <= {w_wval[31:2], 2'b00};
                     CSR_MSCRATCH:      r_mscratch <= w_wval;
                     CSR_MEPC:          r_mepc     <= {w_wval[31:2], 2'b00};
                     CSR_MCAUSE:        r_mcause   <= w_wval;
                     CSR_MTVAL:         r_mtval    <= w_wval;
                     CSR_MCOUNTINHIBIT: r_minh     <= w_wval & MINH_MASK;
                     default: ;
                  endcase
               end
               if (w_trap) begin
                  r_mepc     <= {w_trap_pc[31:2], 2'b00};
                  r_mcause   <= {28'b0, w_trap_cause};
                  r_mtval    <= w_trap_tval;
                  r_mpie     <= r_mie;
                  r_mie      <= 1'b0;
                  r_rpc      <= r_mtvec;
                  r_redirect <= 1'b1;
                  r_state    <= ST_REDIRECT;
               end else if (mret) begin
                  r_mie      <= r_mpie;
                  r_mpie     <= 1'b1;
                  r_rpc      <= r_mepc;
                  r_redirect <= 1'b1;
                  r_state    <= ST_REDIRECT;
               end
            end
            default: begin
               r_redirect <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign csr_rdata   = r_rdata;
   assign redirect    = r_redirect;
   assign redirect_pc = r_rpc;
   assign mstatus_mie = r_mie;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Self-checking bench for csr_trap_unit: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_csr_trap_unit;

   localparam int unsigned CW  = 40;
   localparam int unsigned NH  = 2;
   localparam int unsigned HID = 3;
   localparam logic [31:0] MTV = 32'h0000_0100;
   localparam longint unsigned CMASK = (64'd1 << CW) - 64'd1;

   logic          clk = 1'b0;
   logic          resetb = 1'b0;
   logic          csr_valid = 1'b0;
   logic [1:0]    csr_op = '0;
   logic          csr_imm = 1'b0;
   logic [11:0]   csr_addr = '0;
   logic [31:0]   csr_rs1 = '0;
   logic [4:0]    csr_uimm = '0;
   logic          csr_rd_nz = 1'b0;
   logic [31:0]   csr_rdata;
   logic          retire = 1'b0;
   logic [NH-1:0] hpm_event = '0;
   logic          xb_exc_valid = 1'b0;
   logic [3:0]    xb_exc_cause = '0;
   logic [31:0]   xb_pc = '0;
   logic [31:0]   xb_tval = '0;
   logic          fd_exc_valid = 1'b0;
   logic [3:0]    fd_exc_cause = '0;
   logic [31:0]   fd_pc = '0;
   logic [31:0]   fd_tval = '0;
   logic          mret = 1'b0;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic          mstatus_mie;

   csr_trap_unit #(.CNT_WIDTH(CW), .NUM_HPM(NH), .MTVEC_RESET(MTV), .HART_ID(HID)) dut (
      .clk(clk), .resetb(resetb), .csr_valid(csr_valid), .csr_op(csr_op), .csr_imm(csr_imm),
      .csr_addr(csr_addr), .csr_rs1(csr_rs1), .csr_uimm(csr_uimm), .csr_rd_nz(csr_rd_nz),
      .csr_rdata(csr_rdata), .retire(retire), .hpm_event(hpm_event),
      .xb_exc_valid(xb_exc_valid), .xb_exc_cause(xb_exc_cause), .xb_pc(xb_pc), .xb_tval(xb_tval),
      .fd_exc_valid(fd_exc_valid), .fd_exc_cause(fd_exc_cause), .fd_pc(fd_pc), .fd_tval(fd_tval),
      .mret(mret), .redirect(redirect), .redirect_pc(redirect_pc), .mstatus_mie(mstatus_mie)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   bit              m_redir, m_redirect, m_mie, m_mpie;
   bit [31:0]       m_rdata, m_rpc, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval, m_inh;
   longint unsigned m_cnt [32];

   function automatic bit is_cnt(input int n);
      return n == 0 || n == 2 || (n >= 3 && n < 3 + int'(NH));
   endfunction

   task automatic m_reset();
      m_redir = 0; m_redirect = 0; m_rdata = 0; m_rpc = 0;
      m_mie = 0; m_mpie = 1; m_mtvec = MTV; m_mscratch = 0;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_inh = 0;
      for (int n = 0; n < 32; n++) m_cnt[n] = 0;
   endtask

   function automatic bit [31:0] m_read(input bit [11:0] a, output bit known);
      int n;
      n = int'(a[4:0]);
      known = 1;
      if (a == 12'hF11 || a == 12'hF12 || a == 12'hF13) return 32'h0;
      if (a == 12'hF14) return HID;
      if (a == 12'h300) return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      if (a == 12'h301) return 32'h4000_0100;
      if (a == 12'h305) return m_mtvec;
      if (a == 12'h320) return m_inh;
      if (a == 12'h340) return m_mscratch;
      if (a == 12'h341) return m_mepc;
      if (a == 12'h342) return m_mcause;
      if (a == 12'h343) return m_mtval;
      if (a >= 12'h323 && a <= 12'h33F) return 32'h0;
      if (a >= 12'hB00 && a <= 12'hB1F && n != 1) return is_cnt(n) ? m_cnt[n][31:0] : 32'h0;
      if (a >= 12'hB80 && a <= 12'hB9F && n != 1) return is_cnt(n) ? 32'(m_cnt[n] >> 32) : 32'h0;
      known = 0;
      return 32'h0;
   endfunction

   task automatic m_write(input bit [11:0] a, input bit [31:0] v, output int wn);
      int n;
      n  = int'(a[4:0]);
      wn = -1;
      if (a == 12'h300) begin m_mie = v[3]; m_mpie = v[7]; end
      else if (a == 12'h305) m_mtvec = v & ~32'h3;
      else if (a == 12'h320) m_inh = v & (32'h1 | (((32'h1 << (NH + 1)) - 1) << 2));
      else if (a == 12'h340) m_mscratch = v;
      else if (a == 12'h341) m_mepc = v & ~32'h3;
      else if (a == 12'h342) m_mcause = v;
      else if (a == 12'h343) m_mtval = v;
      else if (a >= 12'hB00 && a <= 12'hB1F && is_cnt(n)) begin
         m_cnt[n] = (m_cnt[n] & 64'hFFFF_FFFF_0000_0000) | 64'(v);
         wn = n;
      end else if (a >= 12'hB80 && a <= 12'hB9F && is_cnt(n)) begin
         m_cnt[n] = ((m_cnt[n] & 64'hFFFF_FFFF) | (64'(v) << 32)) & CMASK;
         wn = n;
      end
   endtask

   // One clock of architectural behaviour, using the currently driven inputs
   task automatic m_step();
      bit known, wi, ill, trap, ev;
      bit [31:0] old, opnd, nv, inh_old, pc, tval;
      bit [3:0] cause;
      int wn;
      inh_old = m_inh;
      m_redirect = 0;
      if (m_redir) begin
         m_redir = 0;
         if (!inh_old[0]) m_cnt[0] = (m_cnt[0] + 1) & CMASK;
         return;
      end
      old  = m_read(csr_addr, known);
      wi   = (csr_op == 2'b01) || (csr_op != 2'b00 && csr_uimm != 5'd0);
      ill  = csr_valid && (!known || (csr_addr[11:8] == 4'hF && wi));
      trap = ill || xb_exc_valid || fd_exc_valid;
      if (csr_valid && csr_rd_nz && !trap) m_rdata = old;
      wn = -1;
      if (csr_valid && wi && !trap) begin
         opnd = csr_imm ? {27'd0, csr_uimm} : csr_rs1;
         nv = (csr_op == 2'b01) ? opnd : (csr_op == 2'b10) ? (old | opnd) : (old & ~opnd);
         m_write(csr_addr, nv, wn);
      end
      for (int n = 0; n < 32; n++) begin
         ev = (n == 0) || (n == 2 && retire && !trap);
         if (n >= 3 && n < 3 + int'(NH)) ev = hpm_event[n-3];
         if (ev && !inh_old[n] && n != wn) m_cnt[n] = (m_cnt[n] + 1) & CMASK;
      end
      if (trap) begin
         if (ill)               begin pc = xb_pc; cause = 4'd2;         tval = 0;       end
         else if (xb_exc_valid) begin pc = xb_pc; cause = xb_exc_cause; tval = xb_tval; end
         else                   begin pc = fd_pc; cause = fd_exc_cause; tval = fd_tval; end
         m_mepc = pc & ~32'h3; m_mcause = {28'd0, cause}; m_mtval = tval;
         m_mpie = m_mie; m_mie = 0;
         m_rpc = m_mtvec; m_redir = 1; m_redirect = 1;
      end else if (mret) begin
         m_mie = m_mpie; m_mpie = 1;
         m_rpc = m_mepc; m_redir = 1; m_redirect = 1;
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic clr();
      csr_valid = 0; csr_op = 0; csr_imm = 0; csr_addr = 0; csr_rs1 = 0; csr_uimm = 0;
      csr_rd_nz = 0; retire = 0; hpm_event = '0; mret = 0;
      xb_exc_valid = 0; xb_exc_cause = 0; xb_pc = 0; xb_tval = 0;
      fd_exc_valid = 0; fd_exc_cause = 0; fd_pc = 0; fd_tval = 0;
   endtask

   task automatic cyc();
      @(posedge clk);
      m_step();
      #1;
      chk("rdata",       csr_rdata,          m_rdata);
      chk("redirect",    32'(redirect),      32'(m_redirect));
      chk("redirect_pc", redirect_pc,        m_rpc);
      chk("mie",         32'(mstatus_mie),   32'(m_mie));
      @(negedge clk);
   endtask

   task automatic csr_do(input bit [1:0] op, input bit imm, input bit [11:0] a,
                         input bit [31:0] rs1, input bit [4:0] uimm);
      clr();
      csr_valid = 1; csr_op = op; csr_imm = imm; csr_addr = a;
      csr_rs1 = rs1; csr_uimm = uimm; csr_rd_nz = 1;
      cyc();
   endtask

   task automatic rd(input bit [11:0] a);
      csr_do(2'b10, 1'b1, a, 32'h0, 5'd0);
   endtask

   bit [11:0] addrs [20] = '{12'h300, 12'h301, 12'h305, 12'h320, 12'h340, 12'h341, 12'h342,
                             12'h343, 12'h323, 12'hF11, 12'hF14, 12'h7C0, 12'hB00, 12'hB80,
                             12'hB02, 12'hB82, 12'hB03, 12'hB84, 12'hB01, 12'hB1F};

   initial begin
      int r;
      clr();
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst_rdata",    csr_rdata,        32'h0);
      chk("rst_redirect", 32'(redirect),    32'h0);
      chk("rst_rpc",      redirect_pc,      32'h0);
      chk("rst_mie",      32'(mstatus_mie), 32'h0);
      resetb = 1;

      rd(12'h301); chk("misa",    csr_rdata, 32'h4000_0100);
      rd(12'hF14); chk("mhartid", csr_rdata, 32'd3);
      rd(12'h305); chk("mtvec",   csr_rdata, 32'h100);
      rd(12'h300); chk("mstatus_rst", csr_rdata, 32'h1880);

      csr_do(2'b01, 0, 12'h340, 32'hDEAD_BEEF, 5'd1); chk("mscratch_rw_old", csr_rdata, 32'h0);
      csr_do(2'b10, 1, 12'h340, 32'h0, 5'h0F);        chk("mscratch_rs",     csr_rdata, 32'hDEAD_BEEF);
      csr_do(2'b11, 1, 12'h340, 32'h0, 5'h00);        chk("mscratch_rc0",    csr_rdata, 32'hDEAD_BEEF);
      rd(12'h340);                                     chk("mscratch_final",  csr_rdata, 32'hDEAD_BEEF);

      csr_do(2'b01, 0, 12'hB80, 32'h0, 5'd1);
      csr_do(2'b01, 0, 12'hB00, 32'hFFFF_FFFF, 5'd1);
      rd(12'hB00); chk("mcycle_no_inc_on_write", csr_rdata, 32'hFFFF_FFFF);
      rd(12'hB80); chk("mcycleh_carry",          csr_rdata, 32'h1);
      csr_do(2'b01, 0, 12'hB80, 32'hFFFF_FFFF, 5'd1);
      rd(12'hB80); chk("mcycleh_trunc",          csr_rdata, 32'hFF);
      csr_do(2'b01, 0, 12'hB00, 32'hFFFF_FFFF, 5'd1);
      rd(12'hB00); chk("mcycle_top",             csr_rdata, 32'hFFFF_FFFF);
      rd(12'hB80); chk("mcycle_wrap",            csr_rdata, 32'h0);

      csr_do(2'b10, 1, 12'h300, 32'h0, 5'h08);
      chk("mie_set", 32'(mstatus_mie), 32'h1);
      clr();
      xb_exc_valid = 1; xb_exc_cause = 4'd4; xb_pc = 32'h200; xb_tval = 32'h203;
      fd_exc_valid = 1; fd_exc_cause = 4'd11; fd_pc = 32'h300; fd_tval = 32'h55; retire = 1;
      cyc();
      chk("trap_redirect", 32'(redirect), 32'h1);
      chk("trap_pc",       redirect_pc,   32'h100);
      chk("trap_mie",      32'(mstatus_mie), 32'h0);
      clr(); mret = 1; cyc();
      chk("redirect_one_cycle", 32'(redirect), 32'h0);
      chk("mret_in_redirect",   redirect_pc,   32'h100);
      rd(12'h341); chk("mepc",   csr_rdata, 32'h200);
      rd(12'h342); chk("mcause", csr_rdata, 32'h4);
      rd(12'h343); chk("mtval",  csr_rdata, 32'h203);
      rd(12'h300); chk("mstatus_trap", csr_rdata, 32'h1880);
      clr(); mret = 1; cyc();
      chk("mret_redirect", 32'(redirect), 32'h1);
      chk("mret_pc",       redirect_pc,   32'h200);
      chk("mret_mie",      32'(mstatus_mie), 32'h1);
      clr(); mret = 1; cyc();
      chk("mret_ignored", 32'(redirect), 32'h0);
      rd(12'h300); chk("mstatus_mret", csr_rdata, 32'h1888);

      csr_do(2'b01, 0, 12'hF11, 32'h5, 5'd1);
      chk("ro_write_trap", 32'(redirect), 32'h1);
      clr(); cyc();
      rd(12'hF11); chk("mvendorid_kept",  csr_rdata, 32'h0);
      rd(12'h342); chk("ro_write_cause",  csr_rdata, 32'h2);
      rd(12'h343); chk("ro_write_tval",   csr_rdata, 32'h0);
      csr_do(2'b01, 0, 12'h340, 32'h0, 5'd1);
      csr_do(2'b10, 1, 12'h7C0, 32'h0, 5'd0);
      chk("unknown_trap", 32'(redirect), 32'h1);
      clr(); cyc();
      rd(12'h342); chk("unknown_cause", csr_rdata, 32'h2);

      // asynchronous reset while the redirect pulse is live
      clr(); xb_exc_valid = 1; xb_exc_cause = 4'd3; xb_pc = 32'h40; cyc();
      chk("pre_reset_redirect", 32'(redirect), 32'h1);
      resetb = 0;
      #1;
      chk("reset_mid_redirect", 32'(redirect), 32'h0);
      chk("reset_mid_rpc",      redirect_pc,   32'h0);
      m_reset();
      @(negedge clk);
      resetb = 1;

      for (int c = 0; c < 800; c++) begin
         clr();
         r = int'($urandom_range(0, 99));
         if (r < 55) begin
            csr_valid = 1;
            csr_addr  = addrs[$urandom_range(0, 19)];
            csr_op    = 2'($urandom_range(0, 3));
            csr_imm   = 1'($urandom_range(0, 1));
            csr_uimm  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            csr_rs1   = $urandom;
            csr_rd_nz = 1'($urandom_range(0, 1));
         end else if (r < 62) begin
            mret = 1;
         end
         if ($urandom_range(0, 15) == 0) begin
            xb_exc_valid = 1; xb_exc_cause = 4'($urandom); xb_pc = $urandom; xb_tval = $urandom;
         end
         if ($urandom_range(0, 15) == 0) begin
            fd_exc_valid = 1; fd_exc_cause = 4'($urandom); fd_pc = $urandom; fd_tval = $urandom;
         end
         retire    = 1'($urandom_range(0, 1));
         hpm_event = NH'($urandom);
         cyc();
      end

      clr();
      for (int n = 0; n < 4; n++) begin
         rd(n == 0 ? 12'hB02 : n == 1 ? 12'hB03 : n == 2 ? 12'hB04 : 12'h320);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
Parametrised machine-mode CSR file with a precise trap/return sequencer for the embedded RV32I core. It sits in the XB stage, executes CSRRW/CSRRS/CSRRC (reg and imm forms) and hosts width-parametrised cycle, instret and HPM counters. It prioritises exceptions from the XB and FD stages, updates mepc/mcause/mtval/mstatus, and drives a one-cycle redirect to the handler or the mret target.

Parameters:
CNT_WIDTH, 64, width of mcycle/minstret/mhpmcounters (33..64); bits above CNT_WIDTH read 0.
NUM_HPM, 2, implemented mhpmcounter3..(3+NUM_HPM-1) (0..29); others read 0, writes ignored.
MTVEC_RESET, 32'h0000_0100, mtvec reset value.
HART_ID, 0, value returned by mhartid.

Ports:
clk  in  1  clock
resetb  in  1  async active-low reset
csr_valid  in  1  XB holds a CSR instruction (not a bubble)
csr_op  in  2  01 write, 10 set, 11 clear, 00 none
csr_imm  in  1  operand is zero-extended uimm
csr_addr  in  12  CSR address
csr_rs1  in  32  rs1 value
csr_uimm  in  5  uimm / rs1 index
csr_rd_nz  in  1  rd != x0
csr_rdata  out  32  registered read data
retire  in  1  XB instruction commits
hpm_event  in  max(NUM_HPM,1)  per-counter increment strobes
xb_exc_valid, xb_exc_cause  in  1, 4  XB-stage exception
xb_pc, xb_tval  in  32, 32
fd_exc_valid, fd_exc_cause  in  1, 4  FD-stage exception
fd_pc, fd_tval  in  32, 32
mret  in  1  XB holds mret
redirect  out  1  one-cycle pipeline redirect/flush
redirect_pc  out  32  handler or return address
mstatus_mie  out  1  current mstatus.MIE

Behaviour:
- Reset: csr_rdata=0, redirect=0, redirect_pc=0, counters=0, mepc/mcause/mtval/mscratch=0, mtvec=MTVEC_RESET, MIE=0, MPIE=1, mcountinhibit=0, state IDLE.
- Operand = csr_imm ? {27'b0,csr_uimm} : csr_rs1. Set/clear with csr_uimm==0 performs no write. Write always writes. Read side effects none; csr_rdata loads old value one cycle after csr_valid whenever csr_rd_nz, otherwise holds.
- CSRs: mvendorid/marchid/mimpid=0, mhartid=HART_ID, misa=32'h4000_0100, mstatus (MIE bit3, MPIE bit7, MPP[12:11] read 2'b11, rest 0), mtvec (bits[1:0] forced 0, direct only), mscratch, mepc (bits[1:0] forced 0), mcause, mtval, mcountinhibit (bits 0,2,3..; bit1 hardwired 0), mcycle/mcycleh, minstret/minstreth, mhpmcounter3..31(h), mhpmevent3..31 (read 0).
- Illegal CSR access: unknown address, or any write/set/clear-with-nonzero-operand to 0xFxx. No state change; treated as XB exception cause 2, tval 0.
- Counters: mcycle +1 each cycle, minstret +1 on retire, hpm[i] +1 on hpm_event[i], each gated by its mcountinhibit bit; wrap mod 2^CNT_WIDTH. CSR write to the counter's low or high half in the same cycle wins over the increment (no +1 that cycle).
- Priority same cycle: illegal CSR > xb_exc > fd_exc > mret. A trapping cycle suppresses the CSR write and the retire increment of the XB instruction.
- FSM IDLE/REDIRECT. IDLE + trap: mepc<=pc, mcause<={28'b0,cause}, mtval<=tval, MPIE<=MIE, MIE<=0, redirect_pc<=mtvec; go REDIRECT. IDLE + mret: MIE<=MPIE, MPIE<=1, redirect_pc<=mepc; go REDIRECT. REDIRECT: redirect=1 for exactly one cycle, all inputs ignored (pipeline flushing), return IDLE.
- Reset asserted mid-REDIRECT: immediately IDLE, redirect=0.

Decomposition:
- Package csr_pkg: CSR address constants, mcause codes (0 inst misaligned, 2 illegal, 3 ebreak, 4 load misaligned, 6 store misaligned, 11 ecall), csr_op encodings, mstatus bit indices.
- Sub-module csr_counter: CNT_WIDTH counter with inhibit, increment strobe, and lo/hi half write ports; instantiated 2+NUM_HPM times.

Test Plan:
- Reset, read misa, mhartid, mtvec -> 32'h4000_0100, HART_ID, 32'h100 one cycle after csr_valid.
- CSRRW mscratch=0xDEAD_BEEF, CSRRS imm 5'h0F, CSRRC imm 0 -> reads 0xDEAD_BEEF then 0xDEAD_BEEF (set ORs 0xF already set), clear-with-0 unchanged.
- mcycle written 32'hFFFF_FFFF, mcycleh 0 -> next cycles read mcycleh=1 after wrap; write cycle shows no extra increment.
- xb_exc(cause 4, pc 0x200, tval 0x203) with simultaneous fd_exc -> mepc 0x200, mcause 4, mtval 0x203, MIE 0, redirect one cycle to mtvec.
- Write to 0xF11 -> cause 2 trap, mvendorid still 0; unknown 0x7C0 same.
- MIE set, trap, then mret -> MIE restored 1, MPIE 1, redirect_pc=mepc; mret during REDIRECT ignored.
